// File: rtl/ps2_direction_decoder.sv
// PS/2 set-2 scan-code decoder that turns make/break sequences into held direction bits for two players.
// Latency: one cycle. Every output is registered and updates on the edge that accepts a byte.
// Backpressure: none. One byte is consumed per rising edge of key_strobe, and a held strobe is not re-consumed.
module ps2_direction_decoder #(
  parameter int PREFIX_TIMEOUT = 1_000_000
) (
  input  logic       clock,
  input  logic       reset,
  input  logic [7:0] key_data,
  input  logic       key_strobe,
  output logic       p0_up,
  output logic       p0_right,
  output logic       p0_down,
  output logic       p0_left,
  output logic       p1_up,
  output logic       p1_right,
  output logic       p1_down,
  output logic       p1_left,
  output logic [7:0] last_code,
  output logic       seq_error
);

  localparam int CW = $clog2(PREFIX_TIMEOUT + 1);

  localparam logic [7:0] CODE_EXT = 8'hE0;
  localparam logic [7:0] CODE_BRK = 8'hF0;

  typedef enum logic [1:0] {
    IDLE,
    EXT,
    BRK,
    EXT_BRK
  } state_t;

  state_t          state;
  logic            key_strobe_q;
  logic [CW-1:0]   tmo_cnt;
  // Direction bits per player, one-hot or zero. Bit order: up, right, down, left.
  logic [3:0]      p0_dir;
  logic [3:0]      p1_dir;

  logic            accept;
  logic            tmo_fire;
  logic            plain_hit;
  logic            ext_hit;
  logic [3:0]      plain_oh;
  logic [3:0]      ext_oh;

  assign accept = key_strobe & ~key_strobe_q;
  // The timeout fires on the edge where the idle count would reach PREFIX_TIMEOUT.
  assign tmo_fire = (state != IDLE) && (tmo_cnt == CW'(PREFIX_TIMEOUT - 1));

  assign p0_up    = p0_dir[0];
  assign p0_right = p0_dir[1];
  assign p0_down  = p0_dir[2];
  assign p0_left  = p0_dir[3];
  assign p1_up    = p1_dir[0];
  assign p1_right = p1_dir[1];
  assign p1_down  = p1_dir[2];
  assign p1_left  = p1_dir[3];

  // Map the incoming byte to a one-hot direction for both the plain (WDSA) and extended (arrow) tables.
  always_comb begin
    plain_oh = 4'b0000;
    ext_oh   = 4'b0000;
    case (key_data)
      8'h1D:   plain_oh = 4'b0001;
      8'h23:   plain_oh = 4'b0010;
      8'h1B:   plain_oh = 4'b0100;
      8'h1C:   plain_oh = 4'b1000;
      default: plain_oh = 4'b0000;
    endcase
    case (key_data)
      8'h75:   ext_oh = 4'b0001;
      8'h74:   ext_oh = 4'b0010;
      8'h72:   ext_oh = 4'b0100;
      8'h6B:   ext_oh = 4'b1000;
      default: ext_oh = 4'b0000;
    endcase
    plain_hit = |plain_oh;
    ext_hit   = |ext_oh;
  end

  // Sequence FSM, prefix timeout and registered direction/debug outputs.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state        <= IDLE;
      key_strobe_q <= 1'b0;
      tmo_cnt      <= '0;
      p0_dir       <= 4'b0000;
      p1_dir       <= 4'b0000;
      last_code    <= 8'h00;
      seq_error    <= 1'b0;
    end else begin
      key_strobe_q <= key_strobe;
      seq_error    <= 1'b0;
      if (accept) begin
        // An accepted byte always beats a timeout that would fire in the same cycle.
        tmo_cnt   <= '0;
        last_code <= key_data;
        case (state)
          IDLE: begin
            if (key_data == CODE_EXT) begin
              state <= EXT;
            end else if (key_data == CODE_BRK) begin
              state <= BRK;
            end else if (plain_hit) begin
              p0_dir <= plain_oh;
            end
          end
          EXT: begin
            if (key_data == CODE_BRK) begin
              state <= EXT_BRK;
            end else if (key_data != CODE_EXT) begin
              if (ext_hit) begin
                p1_dir <= ext_oh;
              end
              state <= IDLE;
            end
          end
          BRK: begin
            if (plain_hit) begin
              p0_dir <= p0_dir & ~plain_oh;
              state  <= IDLE;
            end else if (key_data == CODE_EXT) begin
              state <= EXT_BRK;
            end else if (key_data != CODE_BRK) begin
              state     <= IDLE;
              seq_error <= 1'b1;
            end
          end
          EXT_BRK: begin
            if (ext_hit) begin
              p1_dir <= p1_dir & ~ext_oh;
            end else begin
              seq_error <= 1'b1;
            end
            state <= IDLE;
          end
          default: state <= IDLE;
        endcase
      end else if (state != IDLE) begin
        if (tmo_fire) begin
          // Abandon the partial prefix but leave the held directions alone.
          state     <= IDLE;
          tmo_cnt   <= '0;
          seq_error <= 1'b1;
        end else begin
          tmo_cnt <= tmo_cnt + 1'b1;
        end
      end
    end
  end

endmodule

// File: doc/ps2_direction_decoder.md
# ps2_direction_decoder

Converts the raw PS/2 set-2 scan-code byte stream from the keyboard controller into held, mutually exclusive direction signals for both Pacman players. It sits between the PS/2 interface and the processor skeleton's direction inputs (up/right/down/left, player 0 and player 1), giving keyboard control alongside the board switches. It tracks make/break and extended-prefix sequences with a small FSM and a prefix timeout.

## Interface

- PREFIX_TIMEOUT, 1_000_000: cycles allowed between a prefix byte (E0/F0) and its follow-up byte before the FSM abandons the sequence (20 ms at 50 MHz).
- clock  in  1  system clock (50 MHz domain, same as processor).
- reset  in  1  asynchronous, active-high reset.
- key_data  in  8  scan-code byte from the PS/2 interface.
- key_strobe  in  1  byte-available indication; level or pulse, accepted on its rising edge only.
- p0_up, p0_right, p0_down, p0_left  out  1 each  player 0 held direction (W/D/S/A).
- p1_up, p1_right, p1_down, p1_left  out  1 each  player 1 held direction (arrow keys).
- last_code  out  8  last accepted byte, for seven-segment debug.
- seq_error  out  1  one-cycle pulse when a prefix times out or a break targets an unmapped key.

## Operation

- Interface fact: one clock; reset is asynchronous and active-high.
- Accept: byte consumed on a clock edge where key_strobe=1 and registered key_strobe_q=0. Exactly one byte per rising edge of key_strobe; a held level is not re-consumed.
- FSM states: IDLE, EXT (E0 seen), BRK (F0 seen), EXT_BRK (E0 F0 seen).
- IDLE: E0->EXT; F0->BRK; mapped plain code->make; other codes ignored, stay IDLE.
- EXT: F0->EXT_BRK; E0->stay EXT; mapped extended code->make, ->IDLE; other->IDLE, no change.
- BRK: mapped plain code->break, ->IDLE; F0->stay BRK; E0->EXT_BRK; other->IDLE, seq_error pulse.
- EXT_BRK: mapped extended code->break, ->IDLE; other->IDLE, seq_error pulse.
- Plain map (player 0): 1D up, 23 right, 1B down, 1C left. Extended map (player 1): 75 up, 74 right, 72 down, 6B left. Plain 75/74/72/6B (keypad) and extended 1D/23/1B/1C are unmapped.
- Make: set that player's bit, clear that player's other three bits (most recent key wins). Other player untouched.
- Break: clear that bit only; no effect if already clear. Releasing an older overridden key changes nothing.
- Timeout: counter (width ceil(log2(PREFIX_TIMEOUT+1))) clears on every accepted byte, counts only in EXT/BRK/EXT_BRK; on reaching PREFIX_TIMEOUT -> IDLE, seq_error pulse, outputs unchanged.
- Byte accepted in the same cycle the timeout would fire: byte wins, processed in current state, no seq_error.
- last_code updates on every accepted byte, including prefixes.

## Timing

- Reset values: all eight direction outputs 0, last_code 8'h00, seq_error 0, FSM IDLE, key_strobe_q 0, counter 0.
- Reset mid-sequence (any state) discards partial prefix; first byte after reset is decoded from IDLE.
- key_strobe_q reset to 0: a strobe already high at reset release is accepted on the first edge.
- Latency: outputs and last_code registered; visible one cycle after the accepting edge's inputs are sampled (update on the accepting edge itself).
- seq_error high exactly one cycle.
- All outputs driven directly from flops; no combinational path from key_data to outputs.

## Test plan

- Reset, then strobe 1D -> p0_up=1 next cycle, all others 0, last_code=1D; then F0,1D -> p0_up=0.
- E0,74 -> p1_right=1; then 1C -> p0_left=1 with p1_right still 1; then E0,F0,74 -> p1_right=0, p0_left=1.
- 1D then 23 (no break) -> p0_up=0, p0_right=1; F0,1D -> no change; F0,23 -> p0_right=0.
- Plain 75 -> no output change; E0,1D -> no change, FSM back in IDLE; F0,55 -> seq_error one-cycle pulse.
- PREFIX_TIMEOUT=16: E0 then 20 idle cycles -> seq_error at cycle 16, then 74 alone -> no change; byte on exactly cycle 16 -> decoded, no seq_error.
- key_strobe held high 10 cycles with 1D -> single accept; assert reset mid E0,F0 sequence -> all outputs 0, following 74 ignored.
